// File: rtl/spi_host_seq.sv
// spi_host_seq: SPI host (mode 0) that sends queued command bytes to the
// Logic Sniffer SPI slave. Each byte goes out MSB-first in its own cs_n-framed
// transfer, and the MISO byte captured in that frame is returned on rx_*.
//
// Optional feature macro: SPI_POLL_EN. When defined, an auto-poll engine sends
// POLL_BYTE frames while poll_en_i=1 and the synchronised data_ready_i=1 and
// the TX FIFO is empty. When undefined, poll_en_i/data_ready_i are ignored.
//
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   tx_valid_i/tx_data_i    push into TX FIFO; accepted when tx_ready_o=1
//   tx_ready_o              FIFO not full
//   rx_valid_o/rx_data_o    one-cycle pulse with the MISO byte of a frame
//   rx_is_poll_o            rx_data_o came from an auto-poll frame
//   busy_o                  frame in progress or FIFO non-empty
//   poll_en_i, data_ready_i auto-poll enable, async sniffer dataReady
//   sclk_o, mosi_o, cs_n_o  SPI outputs (sclk idles low)
//   miso_i                  SPI data in
module spi_host_seq #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_SETUP   = 5,
  parameter int unsigned CS_HOLD    = 5,
  parameter int unsigned CS_GAP     = 5,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  POLL_BYTE  = 8'h7F
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_is_poll_o,
  output logic       busy_o,
  input  logic       poll_en_i,
  input  logic       data_ready_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  input  logic       miso_i
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic          rx_valid_q, rx_valid_d, rx_is_poll_q, rx_is_poll_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          poll_q, poll_d;

  // TX FIFO: one extra pointer bit distinguishes full from empty
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, count;
  logic push, pop, empty, poll_go;

  assign count      = wptr_q - rptr_q;
  assign empty      = (count == '0);
  assign tx_ready_o = (count < DEPTH_C);
  assign push       = tx_valid_i & tx_ready_o;

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tx_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

`ifdef SPI_POLL_EN
  logic [1:0] dr_sync_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) dr_sync_q <= '0;
    else         dr_sync_q <= {dr_sync_q[0], data_ready_i};
  end
  // a push landing in the same cycle wins over the poll
  assign poll_go = poll_en_i & dr_sync_q[1] & ~push;
`else
  logic unused_poll;
  assign unused_poll = poll_en_i ^ data_ready_i;
  assign poll_go     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    rx_is_poll_d = rx_is_poll_q;
    poll_d       = poll_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q[AW-1:0]];
          poll_d  = 1'b0;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end else if (poll_go) begin
          sh_d    = POLL_BYTE;
          poll_d  = 1'b1;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd7;
          mosi_d  = sh_q[7];
          sclk_d  = 1'b0;
          state_d = LOW;
        end else cnt_d = cnt_q + CW'(1);
      end
      LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else cnt_d = cnt_q + CW'(1);
      end
      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          // sample on the last high cycle; sh_q doubles as tx and rx shifter
          cnt_d  = '0;
          sclk_d = 1'b0;
          sh_d   = {sh_q[6:0], miso_i};
          if (bit_q == 3'd0) begin
            mosi_d       = 1'b0;
            rx_valid_d   = 1'b1;
            rx_data_d    = {sh_q[6:0], miso_i};
            rx_is_poll_d = poll_q;
            state_d      = HOLD;
          end else begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = sh_q[6];
            state_d = LOW;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = GAP;
        end else cnt_d = cnt_q + CW'(1);
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_is_poll_q <= 1'b0;
      poll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      rx_is_poll_q <= rx_is_poll_d;
      poll_q       <= poll_d;
    end
  end

  assign cs_n_o       = cs_n_q;
  assign sclk_o       = sclk_q;
  assign mosi_o       = mosi_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign rx_is_poll_o = rx_is_poll_q;
  assign busy_o       = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_spi_host_seq.sv
// Bench for spi_host_seq: a mode-0 slave model answers each frame from a
// response queue; a scoreboard pairs each expected frame (mosi byte, miso
// byte, poll flag) with the DUT's rx_valid pulse. Two extra instances with
// CLK_DIV=1 and CLK_DIV=7 run with miso looped back to mosi.
module tb_spi_host_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_valid, tx_ready, rx_valid, rx_is_poll, busy;
  logic [7:0] tx_data, rx_data;
  logic       poll_en, data_ready, sclk, mosi, cs_n;
  logic       miso = 1'b0;
  int         total = 0, bad = 0;

  typedef struct packed { logic [7:0] tx; logic [7:0] rx; logic poll; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] resp_q[$];

  spi_host_seq dut (
    .clock_i(clk), .reset_i(rst), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .rx_is_poll_o(rx_is_poll), .busy_o(busy), .poll_en_i(poll_en),
    .data_ready_i(data_ready), .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n),
    .miso_i(miso));

  // loopback instances: index 0 -> CLK_DIV=1, index 1 -> CLK_DIV=7
  logic [1:0] lb_valid, lb_ready, lb_rxv, lb_poll, lb_busy, lb_sclk, lb_mosi, lb_cs;
  logic [7:0] lb_data;
  logic [7:0] lb_rx [2];

  spi_host_seq #(.CLK_DIV(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .tx_valid_i(lb_valid[0]), .tx_data_i(lb_data),
    .tx_ready_o(lb_ready[0]), .rx_valid_o(lb_rxv[0]), .rx_data_o(lb_rx[0]),
    .rx_is_poll_o(lb_poll[0]), .busy_o(lb_busy[0]), .poll_en_i(1'b0),
    .data_ready_i(1'b0), .sclk_o(lb_sclk[0]), .mosi_o(lb_mosi[0]), .cs_n_o(lb_cs[0]),
    .miso_i(lb_mosi[0]));

  spi_host_seq #(.CLK_DIV(7)) dut7 (
    .clock_i(clk), .reset_i(rst), .tx_valid_i(lb_valid[1]), .tx_data_i(lb_data),
    .tx_ready_o(lb_ready[1]), .rx_valid_o(lb_rxv[1]), .rx_data_o(lb_rx[1]),
    .rx_is_poll_o(lb_poll[1]), .busy_o(lb_busy[1]), .poll_en_i(1'b0),
    .data_ready_i(1'b0), .sclk_o(lb_sclk[1]), .mosi_o(lb_mosi[1]), .cs_n_o(lb_cs[1]),
    .miso_i(lb_mosi[1]));

  // slave model + frame monitor + scoreboard, all sampled on the falling clock
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_rxv = 1'b0, aborted = 1'b0;
  int         lo_cnt = 0, hi_cnt = 0, rises = 0, frames = 0;
  logic [7:0] mosi_cap = 8'h00, slv_sh = 8'h00;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) aborted = 1'b1;
    if (cs_n === 1'b0 && prev_cs === 1'b1) begin
      lo_cnt = 0; rises = 0; aborted = 1'b0; mosi_cap = 8'h00;
      if (frames > 0) begin
        total++;
        if (hi_cnt < 6) begin
          bad++; $display("FAIL cs_gap: got %0d high cycles, need >= 6", hi_cnt);
        end
      end
      slv_sh = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hC3;
      miso   = slv_sh[7];
    end
    if (cs_n === 1'b0) lo_cnt++;
    if (cs_n === 1'b1) hi_cnt++;
    if (cs_n === 1'b1 && prev_cs === 1'b0) begin
      frames++;
      hi_cnt = 1;
      if (!aborted) begin
        total++;
        if (lo_cnt != 42) begin
          bad++; $display("FAIL cs_low_len: got %0d cycles, need 42", lo_cnt);
        end
        total++;
        if (rises != 8) begin
          bad++; $display("FAIL sclk_rises: got %0d, need 8", rises);
        end
      end
    end
    if (cs_n === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (cs_n === 1'b0 && sclk === 1'b0 && prev_sclk === 1'b1) begin
      slv_sh = {slv_sh[6:0], 1'b0};
      miso   = slv_sh[7];
    end
    if (cs_n === 1'b1) miso = 1'b0;
    if (rx_valid === 1'b1) begin
      total++;
      if (prev_rxv === 1'b1) begin
        bad++; $display("FAIL rx_pulse: rx_valid high 2 cycles, need 1");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL rx_unexpected: got rx_data=%h, need no frame", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e.rx || mosi_cap !== e.tx || rx_is_poll !== e.poll) begin
          bad++;
          $display("FAIL frame: got mosi=%h rx=%h poll=%b, need mosi=%h rx=%h poll=%b",
                   mosi_cap, rx_data, rx_is_poll, e.tx, e.rx, e.poll);
        end
      end
    end
    prev_rxv  = rx_valid;
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic push_frame(input logic [7:0] b, input logic [7:0] r);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back('{tx: b, rx: r, poll: 1'b0});
    resp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; poll_en = 1'b0; data_ready = 1'b0;
    lb_valid = 2'b00; lb_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({cs_n, sclk, mosi, tx_ready, rx_valid, rx_data, rx_is_poll, busy} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got cs_n=%b sclk=%b mosi=%b rdy=%b rxv=%b rx=%h poll=%b busy=%b",
               cs_n, sclk, mosi, tx_ready, rx_valid, rx_data, rx_is_poll, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    push_frame(8'h02, 8'h31);
    tx_valid = 1'b0;
    wait_idle(200);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_drain: got %0d pending busy=%b, need 0 pending busy=0",
                      exp_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    int hc;
    seq = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) push_frame(seq[i], 8'($urandom_range(0, 255)));
    tx_valid = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    hc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n === 1'b1) hc++; else hc = 0;
      if (busy === 1'b0) break;
    end
    total++;
    if (hc != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_busy_end: got %0d high cycles at busy=0 (%0d pending), need 6",
                      hc, exp_q.size());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      total++;
      if (tx_ready !== 1'b1) begin
        bad++; $display("FAIL fill_ready: push %0d got tx_ready=%b, need 1", i, tx_ready);
      end
      push_frame(8'(8'h40 + i), 8'($urandom_range(0, 255)));
    end
    total++;
    if (tx_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready: got tx_ready=%b, need 0", tx_ready);
    end
    tx_data = 8'hEE;                     // dropped: FIFO full
    @(negedge clk);
    tx_data = 8'hDD;
    exp_q.push_back('{tx: 8'hDD, rx: 8'h5A, poll: 1'b0});
    resp_q.push_back(8'h5A);
    for (int i = 0; i < 200 && tx_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if (tx_ready !== 1'b0) begin
      bad++; $display("FAIL refill_ready: got tx_ready=%b, need 0 (count back at 16)", tx_ready);
    end
    wait_idle(2000);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL fill_drain: got %0d pending, need 0", exp_q.size());
    end
  endtask

  task automatic test_poll();
    int lows;
`ifdef SPI_POLL_EN
    logic [7:0] r;
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back('{tx: 8'h7F, rx: r, poll: 1'b1});
      resp_q.push_back(r);
    end
    poll_en = 1'b1; data_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() > 1; i++) @(negedge clk);
    for (int i = 0; i < 50 && cs_n !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 50 && cs_n !== 1'b0; i++) @(negedge clk);
    data_ready = 1'b0;
    wait_idle(200);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL poll_frames: got %0d pending, need 0", exp_q.size());
    end
`else
    poll_en = 1'b1; data_ready = 1'b1;
`endif
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL poll_quiet: got %0d active cycles, need 0", lows);
    end
    poll_en = 1'b0; data_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r, act;
    logic ps;
    tx_valid = 1'b1;
    tx_data = 8'h96; @(negedge clk);
    tx_data = 8'h11; @(negedge clk);
    tx_data = 8'h22; @(negedge clk);
    tx_valid = 1'b0;
    r = 0; ps = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk === 1'b1 && ps === 1'b0) r++;
      ps = sclk;
      if (r == 4) break;
    end
    total++;
    if (r != 4) begin
      bad++; $display("FAIL mid_bit4: got %0d sclk rises, need 4", r);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({cs_n, sclk, mosi, rx_valid, tx_ready, busy} !== 6'b100010) begin
      bad++; $display("FAIL mid_reset: got cs_n=%b sclk=%b mosi=%b rxv=%b rdy=%b busy=%b",
                      cs_n, sclk, mosi, rx_valid, tx_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || rx_valid !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++; $display("FAIL mid_flush: got %0d active cycles after reset, need 0", act);
    end
  endtask

  task automatic test_clkdiv(input int sel, input int div);
    int hi_len, lo_len, run, rs, pulses;
    logic ps, s, got;
    logic [7:0] rx;
    total++;
    if (lb_ready[sel] !== 1'b1) begin
      bad++; $display("FAIL lb_ready div%0d: got %b, need 1", div, lb_ready[sel]);
    end
    lb_data = 8'hA5;
    lb_valid[sel] = 1'b1;
    @(negedge clk);
    lb_valid[sel] = 1'b0;
    hi_len = 0; lo_len = 0; run = 0; rs = 0; pulses = 0; ps = 1'b0; got = 1'b0; rx = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s = lb_sclk[sel];
      if (s === ps) run++;
      else begin
        if (ps === 1'b1 && hi_len == 0) hi_len = run;
        if (ps === 1'b0 && rs >= 1 && lo_len == 0) lo_len = run;
        if (s === 1'b1) rs++;
        run = 1;
      end
      ps = s;
      if (lb_rxv[sel] === 1'b1) begin
        pulses++; got = 1'b1; rx = lb_rx[sel];
        if (lb_poll[sel] !== 1'b0) pulses += 100;
      end
      if (got && lb_busy[sel] === 1'b0) break;
    end
    total++;
    if (hi_len != div || lo_len != div) begin
      bad++; $display("FAIL sclk_half div%0d: got high=%0d low=%0d, need %0d", div, hi_len, lo_len, div);
    end
    total++;
    if (rx !== 8'hA5 || pulses != 1 || lb_cs[sel] !== 1'b1) begin
      bad++; $display("FAIL loopback div%0d: got rx=%h pulses=%0d cs_n=%b, need a5 1 1",
                      div, rx, pulses, lb_cs[sel]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_poll();
    test_reset_mid();
    test_clkdiv(0, 1);
    test_clkdiv(1, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
